// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: default geometry and FSM state encoding.
package fetch_pkg;

  localparam int DEF_PROG_CTR_WID = 10;
  localparam int DEF_STACK_DEPTH  = 4;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t BOOT = 2'd0;
  localparam fetch_state_t RUN  = 2'd1;
  localparam fetch_state_t HALT = 2'd2;

endpackage

// File: rtl/ret_addr_stack.sv
// Return-address stack: LIFO of program-counter values with full/empty flags.
// A push while full and a pop while empty are both dropped.
module ret_addr_stack
  import fetch_pkg::*;
#(
  parameter int WID   = DEF_PROG_CTR_WID,
  parameter int DEPTH = DEF_STACK_DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_push,
  input  logic           i_pop,
  input  logic [WID-1:0] i_push_data,
  output logic [WID-1:0] o_top,
  output logic           o_full,
  output logic           o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] SP_FULL = DEPTH[PW:0];
  localparam logic [PW:0] SP_ONE  = {{PW{1'b0}}, 1'b1};

  logic [WID-1:0] r_mem [DEPTH];
  logic [PW:0]    r_sp;
  logic [PW:0]    w_top_ptr;

  assign w_top_ptr = r_sp - SP_ONE;
  assign o_top     = r_mem[w_top_ptr[PW-1:0]];
  assign o_full    = (r_sp == SP_FULL);
  assign o_empty   = (r_sp == '0);

  // NOTE: entries are cleared on reset as well as the pointer, so no stale
  // return address survives a reset; the array is only a handful of words.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push && !o_full) begin
      r_mem[r_sp[PW-1:0]] <= i_push_data;
      r_sp                <= r_sp + SP_ONE;
    end else if (i_pop && !o_empty) begin
      r_sp <= w_top_ptr;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Program-counter / fetch-control stage: BOOT/RUN/HALT sequencing plus branch,
// call and return redirects. Define CALL_STACK_EN to build the return-address stack.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PROG_CTR_WID = DEF_PROG_CTR_WID,
  parameter int STACK_DEPTH  = DEF_STACK_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic                    call,
  input  logic                    ret,
  input  logic [PROG_CTR_WID-1:0] branch_target,
  input  logic                    halt_req,
  input  logic                    resume,
  output logic [PROG_CTR_WID-1:0] prog_ctr,
  output logic                    fetch_valid,
  output logic                    redirect,
  output logic                    halted,
  output logic                    stack_err
);

  localparam logic [PROG_CTR_WID-1:0] PC_ONE = {{(PROG_CTR_WID-1){1'b0}}, 1'b1};

`ifdef CALL_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  fetch_state_t            r_state;
  logic [PROG_CTR_WID-1:0] r_prog_ctr;
  logic                    r_fetch_valid;
  logic                    r_redirect;
  logic                    r_halted;

  fetch_state_t            w_next_state;
  logic [PROG_CTR_WID-1:0] w_next_pc;
  logic [PROG_CTR_WID-1:0] w_pc_inc;
  logic                    w_next_valid;
  logic                    w_next_redirect;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_err_set;
  logic [PROG_CTR_WID-1:0] w_stack_top;
  logic                    w_stack_full;
  logic                    w_stack_empty;

  assign w_pc_inc = r_prog_ctr + PC_ONE;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_next_state    = r_state;
    w_next_pc       = r_prog_ctr;
    w_next_valid    = 1'b0;
    w_next_redirect = 1'b0;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    w_err_set       = 1'b0;
    case (r_state)
      BOOT: begin
        w_next_state = RUN;
        w_next_valid = 1'b1;
      end
      RUN: begin
        if (halt_req) begin
          w_next_state = HALT;
        end else if (STACK_EN && ret && !w_stack_empty) begin
          w_next_pc       = w_stack_top;
          w_pop           = 1'b1;
          w_next_redirect = 1'b1;
          w_next_valid    = 1'b1;
        end else if (STACK_EN && ret) begin
          // Underflow: carry on sequentially and flag it.
          w_next_pc    = w_pc_inc;
          w_err_set    = 1'b1;
          w_next_valid = 1'b1;
        end else if (call || branch_taken) begin
          w_next_pc       = branch_target;
          w_next_redirect = 1'b1;
          w_next_valid    = 1'b1;
          if (call) begin
            w_push    = !w_stack_full;
            w_err_set = w_stack_full;
          end
        end else if (!stall) begin
          w_next_pc    = w_pc_inc;
          w_next_valid = 1'b1;
        end
      end
      HALT: begin
        if (resume) begin
          w_next_state = RUN;
          w_next_pc    = w_pc_inc;
          w_next_valid = 1'b1;
        end
      end
      default: w_next_state = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= BOOT;
      r_prog_ctr    <= '0;
      r_fetch_valid <= 1'b0;
      r_redirect    <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_prog_ctr    <= w_next_pc;
      r_fetch_valid <= w_next_valid;
      r_redirect    <= w_next_redirect;
      r_halted      <= (w_next_state == HALT);
    end
  end

`ifdef CALL_STACK_EN
  logic r_stack_err;

  ret_addr_stack #(
    .WID   (PROG_CTR_WID),
    .DEPTH (STACK_DEPTH)
  ) u_ret_addr_stack (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_pc_inc),
    .o_top       (w_stack_top),
    .o_full      (w_stack_full),
    .o_empty     (w_stack_empty)
  );

  always_ff @(posedge clk) begin
    if (reset)          r_stack_err <= 1'b0;
    else if (w_err_set) r_stack_err <= 1'b1;
  end

  assign stack_err = r_stack_err;
`else
  logic w_unused_stack;

  assign w_stack_top    = '0;
  assign w_stack_full   = 1'b0;
  assign w_stack_empty  = 1'b1;
  assign w_unused_stack = ^{w_push, w_pop, w_err_set};
  assign stack_err      = 1'b0;
`endif

  assign prog_ctr    = r_prog_ctr;
  assign fetch_valid = r_fetch_valid;
  assign redirect    = r_redirect;
  assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, call/return sequences,
// and randomized traffic against a queue-based reference model. Honours CALL_STACK_EN.
module tb_fetch_ctrl;

  localparam int PCW   = 10;
  localparam int DEPTH = 4;
  localparam int PCMOD = 1 << PCW;

`ifdef CALL_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset, stall, branch_taken, call, ret, halt_req, resume;
  logic [PCW-1:0] branch_target;
  logic [PCW-1:0] prog_ctr;
  logic           fetch_valid, redirect, halted, stack_err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.PROG_CTR_WID(PCW), .STACK_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .call          (call),
    .ret           (ret),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .resume        (resume),
    .prog_ctr      (prog_ctr),
    .fetch_valid   (fetch_valid),
    .redirect      (redirect),
    .halted        (halted),
    .stack_err     (stack_err)
  );

  typedef struct {
    bit rst, stl, br, cl, rt, hlt, res;
    int tgt;
    int pc;
    bit val, rdr, hltd;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge sample them, then settle.
  task automatic drive(input bit rst, input bit stl, input bit br, input bit cl,
                       input bit rt, input bit hlt, input bit res, input int tgt);
    reset = rst; stall = stl; branch_taken = br; call = cl; ret = rt;
    halt_req = hlt; resume = res; branch_target = PCW'(tgt);
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input bit rst, input bit stl, input bit br, input bit cl,
                              input bit rt, input bit hlt, input bit res, input int tgt,
                              input int pc, input bit val, input bit rdr, input bit hltd);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.cl = cl; v.rt = rt; v.hlt = hlt; v.res = res;
    v.tgt = tgt; v.pc = pc; v.val = val; v.rdr = rdr; v.hltd = hltd;
    tbl.push_back(v);
  endfunction

  task automatic hs(input bit stl, input bit br, input bit cl, input bit rt, input int tgt,
                    input int epc, input bit erdr, input bit eerr, input string nm);
    drive(1'b0, stl, br, cl, rt, 1'b0, 1'b0, tgt);
    check({nm, "_pc"},    int'(prog_ctr),    epc);
    check({nm, "_valid"}, int'(fetch_valid), 1);
    check({nm, "_redir"}, int'(redirect),    int'(erdr));
    check({nm, "_err"},   int'(stack_err),   int'(eerr));
  endtask

  task automatic do_rst(input string nm);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'h155);
    check({nm, "_rst_pc"},    int'(prog_ctr),    0);
    check({nm, "_rst_valid"}, int'(fetch_valid), 0);
    check({nm, "_rst_err"},   int'(stack_err),   0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check({nm, "_boot_pc"},    int'(prog_ctr),    0);
    check({nm, "_boot_valid"}, int'(fetch_valid), 1);
  endtask

  // Reference model: mode 0=boot, 1=run, 2=halt; return addresses in a queue.
  int m_pc, m_mode;
  int m_ras[$];
  bit m_err, m_valid, m_redir, m_halted;

  function automatic void model_step(input bit rst, input bit stl, input bit br, input bit cl,
                                     input bit rt, input bit hlt, input bit res, input int tgt);
    m_valid = 1'b0;
    m_redir = 1'b0;
    if (rst) begin
      m_mode = 0; m_pc = 0; m_err = 1'b0; m_ras.delete();
    end else if (m_mode == 0) begin
      m_mode = 1; m_valid = 1'b1;
    end else if (m_mode == 1) begin
      if (hlt) begin
        m_mode = 2;
      end else if (STK && rt && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back(); m_redir = 1'b1; m_valid = 1'b1;
      end else if (STK && rt) begin
        m_pc = (m_pc + 1) % PCMOD; m_err = 1'b1; m_valid = 1'b1;
      end else if (cl || br) begin
        if (STK && cl) begin
          if (m_ras.size() < DEPTH) m_ras.push_back((m_pc + 1) % PCMOD);
          else m_err = 1'b1;
        end
        m_pc = tgt; m_redir = 1'b1; m_valid = 1'b1;
      end else if (!stl) begin
        m_pc = (m_pc + 1) % PCMOD; m_valid = 1'b1;
      end
    end else if (res) begin
      m_mode = 1; m_pc = (m_pc + 1) % PCMOD; m_valid = 1'b1;
    end
    m_halted = (m_mode == 2);
  endfunction

  initial begin
    // Directed table: reset, idle count, branch over stall, wrap, halt/resume, reset in halt.
    add(1,0,0,0,0,0,0,'h000, 'h000,0,0,0);
    for (int k = 0; k < 6; k++) add(0,0,0,0,0,0,0,'h000, k,(k == 0) ? 1'b1 : 1'b1,0,0);
    add(0,1,1,0,0,0,0,'h100, 'h100,1,1,0);
    add(0,0,0,0,0,0,0,'h000, 'h101,1,0,0);
    add(0,1,0,0,0,0,0,'h000, 'h101,0,0,0);
    add(0,0,0,0,0,0,0,'h000, 'h102,1,0,0);
    add(0,0,1,0,0,0,0,'h3FE, 'h3FE,1,1,0);
    add(0,0,0,0,0,0,0,'h000, 'h3FF,1,0,0);
    add(0,0,0,0,0,0,0,'h000, 'h000,1,0,0);
    add(0,0,1,0,0,0,0,'h020, 'h020,1,1,0);
    add(0,0,0,0,0,0,0,'h000, 'h021,1,0,0);
    add(0,0,1,0,0,1,0,'h300, 'h021,0,0,1);
    for (int k = 0; k < 10; k++)
      add(0,k[0],(k % 3) != 0,(k % 3) == 0,(k % 4) == 1,k[1],0,'h100 + k, 'h021,0,0,1);
    add(0,0,1,0,0,0,1,'h3C0, 'h022,1,0,0);
    add(0,0,0,0,0,1,0,'h000, 'h022,0,0,1);
    add(1,0,1,0,0,0,1,'h123, 'h000,0,0,0);
    add(0,0,0,0,0,0,0,'h000, 'h000,1,0,0);
    add(0,0,0,0,0,0,0,'h000, 'h001,1,0,0);
    // The first table row shows BOOT after reset; the next idle row enters RUN at 0.
    tbl[0].val = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].stl, tbl[i].br, tbl[i].cl, tbl[i].rt, tbl[i].hlt, tbl[i].res, tbl[i].tgt);
      check($sformatf("tbl%0d_pc", i),     int'(prog_ctr),    tbl[i].pc);
      check($sformatf("tbl%0d_valid", i),  int'(fetch_valid), int'(tbl[i].val));
      check($sformatf("tbl%0d_redir", i),  int'(redirect),    int'(tbl[i].rdr));
      check($sformatf("tbl%0d_halted", i), int'(halted),      int'(tbl[i].hltd));
      check($sformatf("tbl%0d_err", i),    int'(stack_err),   0);
    end

    // Call, three sequential fetches, return.
    do_rst("call");
    hs(0,1,0,0,'h010, 'h010,1,0,"call_goto");
    hs(0,0,1,0,'h200, 'h200,1,0,"call_jump");
    hs(0,0,0,0,'h000, 'h201,0,0,"call_seq1");
    hs(0,0,0,0,'h000, 'h202,0,0,"call_seq2");
    hs(0,0,0,0,'h000, 'h203,0,0,"call_seq3");
    hs(0,0,0,1,'h000, STK ? 'h011 : 'h204, STK,0,"call_ret");

    // Five nested calls into a four-deep stack, then five returns.
    do_rst("nest");
    hs(0,1,0,0,'h030, 'h030,1,0,"nest_goto");
    hs(0,0,1,0,'h040, 'h040,1,0,"nest_call1");
    hs(0,0,1,0,'h080, 'h080,1,0,"nest_call2");
    hs(0,0,1,0,'h0C0, 'h0C0,1,0,"nest_call3");
    hs(0,0,1,0,'h100, 'h100,1,0,"nest_call4");
    hs(0,0,1,0,'h140, 'h140,1,STK,"nest_call5");
    hs(0,0,0,1,'h000, STK ? 'h0C1 : 'h141, STK,STK,"nest_ret1");
    hs(0,0,0,1,'h000, STK ? 'h081 : 'h142, STK,STK,"nest_ret2");
    hs(0,0,0,1,'h000, STK ? 'h041 : 'h143, STK,STK,"nest_ret3");
    hs(0,0,0,1,'h000, STK ? 'h031 : 'h144, STK,STK,"nest_ret4");
    hs(0,0,0,1,'h000, STK ? 'h032 : 'h145, 0,STK,"nest_ret5");

    // Call from the top address pushes the wrapped return address.
    do_rst("wrap");
    hs(0,1,0,0,'h3FF, 'h3FF,1,0,"wrap_goto");
    hs(0,0,1,0,'h050, 'h050,1,0,"wrap_call");
    hs(0,0,0,1,'h000, STK ? 'h000 : 'h051, STK,0,"wrap_ret");

    // Randomized traffic against the reference model.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int c = 0; c < 3000; c++) begin
      bit rst, stl, br, cl, rt, hlt, res;
      int tgt;
      rst = ($urandom_range(0, 299) == 0);
      stl = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 6) == 0);
      cl  = ($urandom_range(0, 6) == 0);
      rt  = ($urandom_range(0, 6) == 0);
      hlt = ($urandom_range(0, 24) == 0);
      res = ($urandom_range(0, 2) == 0);
      tgt = int'($urandom_range(0, PCMOD - 1));
      drive(rst, stl, br, cl, rt, hlt, res, tgt);
      model_step(rst, stl, br, cl, rt, hlt, res, tgt);
      check($sformatf("rnd%0d_pc", c),     int'(prog_ctr),    m_pc);
      check($sformatf("rnd%0d_valid", c),  int'(fetch_valid), int'(m_valid));
      check($sformatf("rnd%0d_redir", c),  int'(redirect),    int'(m_redir));
      check($sformatf("rnd%0d_halted", c), int'(halted),      int'(m_halted));
      check($sformatf("rnd%0d_err", c),    int'(stack_err),   int'(m_err));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
